alu_issue_stage: RTL and testbench
==================================

// Module: alu_issue_stage
// PURPOSE
//  ID/EX stage of the RV32I core, directly upstream of the ALU. Decodes R-type (0110011) and I-type ALU (0010011)
//  instructions into the 4-bit ALU opcode, selects and forwards operands, and registers them for the ALU.
//  Valid/ready pipeline register with stall (backpressure) and flush. Outputs drive alu a_i/b_i/op_i directly.
// PARAMETERS
//  DATA_WIDTH  32  datapath width; decode fields assume 32-bit RV32I encoding
//  OP_WIDTH    4   ALU opcode width
// PORTS
//  clk          in   1            clock, all state updates on rising edge
//  rst          in   1            synchronous active-high reset
//  flush_i      in   1            discard held and incoming instruction (branch/trap redirect)
//  in_valid_i   in   1            instr_i/rs*_data_i valid
//  in_ready_o   out  1            stage can accept this cycle
//  instr_i      in   32           instruction word
//  rs1_addr_o   out  5            instr_i[19:15], combinational, to regfile
//  rs2_addr_o   out  5            instr_i[24:20], combinational, to regfile
//  rs1_data_i   in   DATA_WIDTH   regfile read data port 1
//  rs2_data_i   in   DATA_WIDTH   regfile read data port 2
//  ex_wr_en_i   in   1            EX-stage result will be written back
//  ex_rd_i      in   5            EX-stage destination register
//  ex_res_i     in   DATA_WIDTH   EX-stage ALU result (forwarding source)
//  out_valid_o  out  1            registered operands valid
//  out_ready_i  in   1            downstream accepts
//  a_o          out  DATA_WIDTH   ALU operand a
//  b_o          out  DATA_WIDTH   ALU operand b
//  op_o         out  OP_WIDTH     ALU opcode
//  rd_o         out  5            destination register
//  wr_en_o      out  1            writeback enable (0 for rd=x0 or illegal)
//  illegal_o    out  1            instruction not a legal R/I ALU op
// BEHAVIOUR
//  - Opcodes: 0 add,1 sub,2 sll,3 slt,4 sltu,5 xor,6 srl,7 sra,8 or,9 and.
//  - R-type funct3: 000 add (funct7 0000000) / sub (0100000); 001 sll; 010 slt; 011 sltu; 100 xor;
//    101 srl (0000000) / sra (0100000); 110 or; 111 and. funct7 other than listed -> illegal.
//  - I-type: 000 addi (never sub); 010 slti; 011 sltiu; 100/110/111 xori/ori/andi; 001 slli needs funct7=0;
//    101 srli/srai by funct7 as above; other funct7 on shifts -> illegal.
//  - b operand: R non-shift = rs2 value; I non-shift = sign-extended instr[31:20] (sltiu uses same sext);
//    all shifts: b = {27'b0, amount[4:0]} (R: rs2 value[4:0], I: instr[24:20]). a = rs1 value.
//  - Forwarding: rs1/rs2 value = ex_res_i when ex_wr_en_i && ex_rd_i!=0 && ex_rd_i==rsN addr, else rsN_data_i.
//    Sampled in the load cycle only; held values are never re-forwarded.
//  - Illegal (any other opcode/funct7): op_o=0, a_o=b_o=0, wr_en_o=0, illegal_o=1, still passes as valid.
//  - wr_en_o = legal && rd!=0.
//  - Handshake: in_ready_o = !out_valid_o || out_ready_i (comb). load = in_valid_i && in_ready_o.
//    Latency 1 cycle: loaded data visible on outputs the cycle after load.
//  - out_valid_o next: flush_i -> 0; else load -> 1; else out_ready_i -> 0; else hold.
//  - Output regs update only on load && !flush_i; otherwise hold (including during stall).
//  - flush_i has priority over load and over hold; flushed input is dropped, not stalled.
//  - Reset (priority over flush): out_valid_o=0, a_o=b_o=0, op_o=0, rd_o=0, wr_en_o=0, illegal_o=0.
//    Reset mid-stall discards held instruction. in_ready_o=1 from the cycle after reset.
// TESTING
//  1 addi x1,x0,-5 (0xFFB00093), rs1_data=0 -> next cycle a=0, b=0xFFFFFFFB, op=0, rd=1, wr_en=1, valid=1.
//  2 sub x3,x1,x2 (0x402081B3), rs1=10, rs2=3, ex_wr_en=1 ex_rd=1 ex_res=0x1234 -> a=0x1234, b=3, op=1.
//  3 srai x5,x6,31 (0x41F35293), rs1=0x80000000 -> a=0x80000000, b=0x1F, op=7; funct7=0x60 -> illegal=1.
//  4 Backpressure: out_valid=1, out_ready=0 for 2 cycles, new in_valid -> in_ready=0, outputs unchanged;
//    out_ready=1 -> in_ready=1, new instr loaded next cycle with no bubble and no loss.
//  5 flush_i with in_valid=1 during stall -> out_valid=0 next cycle, incoming instr dropped; rst same cycle wins.
//  6 ecall (0x00000073) and add x0,x1,x2 -> illegal=1/wr_en=0 and illegal=0/wr_en=0 respectively.

Source files
------------

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decodes RV32I R/I ALU ops, forwards from EX, and
// registers operands for the ALU behind a valid/ready pipeline register.
// Ports:
//   clk, rst             clock, sync active-high reset
//   flush_i              drop held and incoming instruction
//   in_valid_i/in_ready_o   upstream handshake
//   instr_i              instruction word
//   rs1_addr_o/rs2_addr_o   regfile read addresses (comb)
//   rs1_data_i/rs2_data_i   regfile read data
//   ex_wr_en_i/ex_rd_i/ex_res_i  EX forwarding source
//   out_valid_o/out_ready_i downstream handshake
//   a_o, b_o, op_o       ALU operands and opcode
//   rd_o, wr_en_o        destination and writeback enable
//   illegal_o            not a legal R/I ALU op
module alu_issue_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [31:0]           instr_i,
  output logic [4:0]            rs1_addr_o,
  output logic [4:0]            rs2_addr_o,
  input  logic [DATA_WIDTH-1:0] rs1_data_i,
  input  logic [DATA_WIDTH-1:0] rs2_data_i,
  input  logic                  ex_wr_en_i,
  input  logic [4:0]            ex_rd_i,
  input  logic [DATA_WIDTH-1:0] ex_res_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] a_o,
  output logic [DATA_WIDTH-1:0] b_o,
  output logic [OP_WIDTH-1:0]   op_o,
  output logic [4:0]            rd_o,
  output logic                  wr_en_o,
  output logic                  illegal_o
);

  localparam logic [6:0] OPC_R = 7'b0110011;
  localparam logic [6:0] OPC_I = 7'b0010011;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [OP_WIDTH-1:0] OP_ADD  = OP_WIDTH'(0);
  localparam logic [OP_WIDTH-1:0] OP_SUB  = OP_WIDTH'(1);
  localparam logic [OP_WIDTH-1:0] OP_SLL  = OP_WIDTH'(2);
  localparam logic [OP_WIDTH-1:0] OP_SLT  = OP_WIDTH'(3);
  localparam logic [OP_WIDTH-1:0] OP_SLTU = OP_WIDTH'(4);
  localparam logic [OP_WIDTH-1:0] OP_XOR  = OP_WIDTH'(5);
  localparam logic [OP_WIDTH-1:0] OP_SRL  = OP_WIDTH'(6);
  localparam logic [OP_WIDTH-1:0] OP_SRA  = OP_WIDTH'(7);
  localparam logic [OP_WIDTH-1:0] OP_OR   = OP_WIDTH'(8);
  localparam logic [OP_WIDTH-1:0] OP_AND  = OP_WIDTH'(9);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd_f;
  logic       is_r;
  logic       is_i;
  logic       f7_zero;
  logic       f7_alt;

  assign opcode  = instr_i[6:0];
  assign funct3  = instr_i[14:12];
  assign funct7  = instr_i[31:25];
  assign rd_f    = instr_i[11:7];
  assign is_r    = (opcode == OPC_R);
  assign is_i    = (opcode == OPC_I);
  assign f7_zero = (funct7 == F7_ZERO);
  assign f7_alt  = (funct7 == F7_ALT);

  assign rs1_addr_o = instr_i[19:15];
  assign rs2_addr_o = instr_i[24:20];

  logic [OP_WIDTH-1:0] op_dec;
  logic                legal;
  logic                shift;

  // Shifts carry funct7 in both formats; I-type non-shifts
  // reuse those bits as immediate, so funct7 is ignored there.
  always_comb begin
    op_dec = OP_ADD;
    legal  = 1'b0;
    shift  = 1'b0;
    unique case (1'b1)
      is_r: begin
        unique case (funct3)
          3'b000: begin
            op_dec = f7_alt ? OP_SUB : OP_ADD;
            legal  = f7_zero || f7_alt;
          end
          3'b001: begin
            op_dec = OP_SLL;
            legal  = f7_zero;
            shift  = 1'b1;
          end
          3'b010: begin
            op_dec = OP_SLT;
            legal  = f7_zero;
          end
          3'b011: begin
            op_dec = OP_SLTU;
            legal  = f7_zero;
          end
          3'b100: begin
            op_dec = OP_XOR;
            legal  = f7_zero;
          end
          3'b101: begin
            op_dec = f7_alt ? OP_SRA : OP_SRL;
            legal  = f7_zero || f7_alt;
            shift  = 1'b1;
          end
          3'b110: begin
            op_dec = OP_OR;
            legal  = f7_zero;
          end
          3'b111: begin
            op_dec = OP_AND;
            legal  = f7_zero;
          end
          default: ;
        endcase
      end
      is_i: begin
        unique case (funct3)
          3'b000: begin
            op_dec = OP_ADD;
            legal  = 1'b1;
          end
          3'b001: begin
            op_dec = OP_SLL;
            legal  = f7_zero;
            shift  = 1'b1;
          end
          3'b010: begin
            op_dec = OP_SLT;
            legal  = 1'b1;
          end
          3'b011: begin
            op_dec = OP_SLTU;
            legal  = 1'b1;
          end
          3'b100: begin
            op_dec = OP_XOR;
            legal  = 1'b1;
          end
          3'b101: begin
            op_dec = f7_alt ? OP_SRA : OP_SRL;
            legal  = f7_zero || f7_alt;
            shift  = 1'b1;
          end
          3'b110: begin
            op_dec = OP_OR;
            legal  = 1'b1;
          end
          3'b111: begin
            op_dec = OP_AND;
            legal  = 1'b1;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // x0 is never a forwarding match: its value is always zero.
  logic                  fwd1;
  logic                  fwd2;
  logic [DATA_WIDTH-1:0] rs1_val;
  logic [DATA_WIDTH-1:0] rs2_val;

  assign fwd1 = ex_wr_en_i && (ex_rd_i != 5'd0) &&
                (ex_rd_i == rs1_addr_o);
  assign fwd2 = ex_wr_en_i && (ex_rd_i != 5'd0) &&
                (ex_rd_i == rs2_addr_o);

  assign rs1_val = fwd1 ? ex_res_i : rs1_data_i;
  assign rs2_val = fwd2 ? ex_res_i : rs2_data_i;

  logic [DATA_WIDTH-1:0] imm_sext;
  logic [4:0]            shamt;

  assign imm_sext = {{(DATA_WIDTH-12){instr_i[31]}},
                     instr_i[31:20]};
  assign shamt    = is_r ? rs2_val[4:0] : instr_i[24:20];

  logic [DATA_WIDTH-1:0] a_d;
  logic [DATA_WIDTH-1:0] b_d;
  logic [OP_WIDTH-1:0]   op_d;
  logic [4:0]            rd_d;
  logic                  wr_en_d;
  logic                  illegal_d;

  always_comb begin
    a_d       = '0;
    b_d       = '0;
    op_d      = OP_ADD;
    rd_d      = rd_f;
    wr_en_d   = 1'b0;
    illegal_d = 1'b1;
    if (legal) begin
      a_d       = rs1_val;
      op_d      = op_dec;
      wr_en_d   = (rd_f != 5'd0);
      illegal_d = 1'b0;
      if (shift) begin
        b_d = {{(DATA_WIDTH-5){1'b0}}, shamt};
      end else if (is_r) begin
        b_d = rs2_val;
      end else begin
        b_d = imm_sext;
      end
    end
  end

  logic                  valid_q;
  logic                  valid_d;
  logic [DATA_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] b_q;
  logic [OP_WIDTH-1:0]   op_q;
  logic [4:0]            rd_q;
  logic                  wr_en_q;
  logic                  illegal_q;
  logic                  load;
  logic                  capture;

  assign in_ready_o = !valid_q || out_ready_i;
  assign load       = in_valid_i && in_ready_o;
  assign capture    = load && !flush_i;

  always_comb begin
    valid_d = valid_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
    end else if (out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      rd_q      <= '0;
      wr_en_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      if (capture) begin
        a_q       <= a_d;
        b_q       <= b_d;
        op_q      <= op_d;
        rd_q      <= rd_d;
        wr_en_q   <= wr_en_d;
        illegal_q <= illegal_d;
      end
    end
  end

  assign out_valid_o = valid_q;
  assign a_o         = a_q;
  assign b_o         = b_q;
  assign op_o        = op_q;
  assign rd_o        = rd_q;
  assign wr_en_o     = wr_en_q;
  assign illegal_o   = illegal_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: scoreboard queue filled
// at issue, drained by a monitor on each output handshake.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] instr_i;
  logic [4:0]  rs1_addr_o;
  logic [4:0]  rs2_addr_o;
  logic [31:0] rs1_data_i;
  logic [31:0] rs2_data_i;
  logic        ex_wr_en_i;
  logic [4:0]  ex_rd_i;
  logic [31:0] ex_res_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] a_o;
  logic [31:0] b_o;
  logic [3:0]  op_o;
  logic [4:0]  rd_o;
  logic        wr_en_o;
  logic        illegal_o;

  alu_issue_stage #(.DATA_WIDTH(32), .OP_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .instr_i(instr_i),
    .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
    .ex_wr_en_i(ex_wr_en_i), .ex_rd_i(ex_rd_i),
    .ex_res_i(ex_res_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .a_o(a_o), .b_o(b_o), .op_o(op_o), .rd_o(rd_o),
    .wr_en_o(wr_en_o), .illegal_o(illegal_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ins;
    logic [31:0] r1;
    logic [31:0] r2;
    logic        we;
    logic [4:0]  erd;
    logic [31:0] eres;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        wr;
    logic        ill;
  } vec_t;

  vec_t vt[12];
  vec_t sb[$];
  int   nvec = 0;
  int   nerr = 0;
  logic mon_en = 1'b0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    instr_i    = v.ins;
    rs1_data_i = v.r1;
    rs2_data_i = v.r2;
    ex_wr_en_i = v.we;
    ex_rd_i    = v.erd;
    ex_res_i   = v.eres;
    in_valid_i = 1'b1;
  endtask

  task automatic chk_held(input string nm, input vec_t v);
    chk({nm, ".valid"}, 32'(out_valid_o), 32'd1);
    chk({nm, ".a"}, a_o, v.a);
    chk({nm, ".b"}, b_o, v.b);
    chk({nm, ".op"}, 32'(op_o), 32'(v.op));
  endtask

  // Monitor: a transfer happens on each edge where valid && ready.
  always @(negedge clk) begin
    if (mon_en && out_valid_o === 1'b1 && out_ready_i === 1'b1) begin
      nvec++;
      if (sb.size() == 0) begin
        nerr++;
        $display("FAIL mon: unexpected output a=%h op=%h", a_o, op_o);
      end else begin
        vec_t e;
        e = sb.pop_front();
        if (a_o !== e.a || b_o !== e.b || op_o !== e.op ||
            wr_en_o !== e.wr || illegal_o !== e.ill ||
            (!e.ill && rd_o !== e.rd)) begin
          nerr++;
          $display("FAIL mon %h: got a=%h b=%h op=%h rd=%h wr=%b il=%b required a=%h b=%h op=%h rd=%h wr=%b il=%b",
                   e.ins, a_o, b_o, op_o, rd_o, wr_en_o, illegal_o,
                   e.a, e.b, e.op, e.rd, e.wr, e.ill);
        end
      end
    end
  end

  initial begin
    vt[0]  = '{32'hFFB00093, 0, 0, 0, 0, 0,
               32'h0, 32'hFFFFFFFB, 4'd0, 5'd1, 1, 0};
    vt[1]  = '{32'h402081B3, 10, 3, 1, 1, 32'h1234,
               32'h1234, 32'h3, 4'd1, 5'd3, 1, 0};
    vt[2]  = '{32'h41F35293, 32'h80000000, 0, 0, 0, 0,
               32'h80000000, 32'h1F, 4'd7, 5'd5, 1, 0};
    vt[3]  = '{32'hC1F35293, 32'h80000000, 0, 0, 0, 0,
               0, 0, 4'd0, 5'd5, 0, 1};
    vt[4]  = '{32'h00000073, 32'h55, 32'h66, 0, 0, 0,
               0, 0, 4'd0, 5'd0, 0, 1};
    vt[5]  = '{32'h00208033, 5, 7, 0, 0, 0,
               5, 7, 4'd0, 5'd0, 0, 0};
    vt[6]  = '{32'h00209233, 1, 32'hFFFFFF25, 0, 0, 0,
               1, 5, 4'd2, 5'd4, 1, 0};
    vt[7]  = '{32'hFFF43393, 32'h42, 0, 0, 0, 0,
               32'h42, 32'hFFFFFFFF, 4'd4, 5'd7, 1, 0};
    vt[8]  = '{32'h00B574B3, 32'hFF00FF00, 32'h0F0F0F0F, 0, 0, 0,
               32'hFF00FF00, 32'h0F0F0F0F, 4'd9, 5'd9, 1, 0};
    vt[9]  = '{32'h40309093, 7, 0, 0, 0, 0,
               0, 0, 4'd0, 5'd1, 0, 1};
    vt[10] = '{32'h000001B3, 32'h11, 32'h22, 1, 0, 32'hDEAD,
               32'h11, 32'h22, 4'd0, 5'd3, 1, 0};
    vt[11] = '{32'h00524133, 32'hF0F0F0F0, 0, 1, 5, 32'h0F0F0000,
               32'hF0F0F0F0, 32'h0F0F0000, 4'd5, 5'd2, 1, 0};

    rst = 1'b1;
    flush_i = 1'b0;
    in_valid_i = 1'b0;
    out_ready_i = 1'b1;
    instr_i = '0;
    rs1_data_i = '0;
    rs2_data_i = '0;
    ex_wr_en_i = 1'b0;
    ex_rd_i = '0;
    ex_res_i = '0;
    repeat (3) step();
    rst = 1'b0;

    chk("rst.valid", 32'(out_valid_o), 0);
    chk("rst.a", a_o, 0);
    chk("rst.b", b_o, 0);
    chk("rst.op", 32'(op_o), 0);
    chk("rst.rd", 32'(rd_o), 0);
    chk("rst.wr", 32'(wr_en_o), 0);
    chk("rst.ill", 32'(illegal_o), 0);
    chk("rst.ready", 32'(in_ready_o), 1);
    mon_en = 1'b1;

    // Back-to-back stream, downstream always ready.
    for (int i = 0; i < 12; i++) begin
      drive(vt[i]);
      #1;
      chk("rs1_addr", 32'(rs1_addr_o), 32'(vt[i].ins[19:15]));
      chk("rs2_addr", 32'(rs2_addr_o), 32'(vt[i].ins[24:20]));
      chk("stream.ready", 32'(in_ready_o), 1);
      sb.push_back(vt[i]);
      step();
    end
    in_valid_i = 1'b0;
    repeat (2) step();

    // Backpressure: A held two cycles while B waits.
    out_ready_i = 1'b0;
    drive(vt[6]);
    sb.push_back(vt[6]);
    step();
    drive(vt[7]);
    #1;
    chk("bp.ready0", 32'(in_ready_o), 0);
    step();
    chk_held("bp.hold1", vt[6]);
    chk("bp.ready1", 32'(in_ready_o), 0);
    step();
    chk_held("bp.hold2", vt[6]);
    out_ready_i = 1'b1;
    #1;
    chk("bp.release", 32'(in_ready_o), 1);
    sb.push_back(vt[7]);
    step();
    in_valid_i = 1'b0;
    chk_held("bp.next", vt[7]);
    repeat (2) step();

    // Flush during stall drops both held and incoming.
    out_ready_i = 1'b0;
    drive(vt[8]);
    sb.push_back(vt[8]);
    step();
    drive(vt[9]);
    flush_i = 1'b1;
    sb.delete();
    step();
    flush_i = 1'b0;
    in_valid_i = 1'b0;
    chk("fl.valid", 32'(out_valid_o), 0);
    chk("fl.a_hold", a_o, vt[8].a);
    chk("fl.ill_hold", 32'(illegal_o), 0);
    out_ready_i = 1'b1;
    repeat (2) step();

    // Reset and flush together mid-stall.
    out_ready_i = 1'b0;
    drive(vt[0]);
    sb.push_back(vt[0]);
    step();
    drive(vt[1]);
    flush_i = 1'b1;
    rst = 1'b1;
    sb.delete();
    step();
    rst = 1'b0;
    flush_i = 1'b0;
    in_valid_i = 1'b0;
    chk("rf.valid", 32'(out_valid_o), 0);
    chk("rf.a", a_o, 0);
    chk("rf.b", b_o, 0);
    chk("rf.wr", 32'(wr_en_o), 0);
    chk("rf.ready", 32'(in_ready_o), 1);
    out_ready_i = 1'b1;

    // One more transfer after reset to prove recovery.
    drive(vt[2]);
    sb.push_back(vt[2]);
    step();
    in_valid_i = 1'b0;

    for (int i = 0; i < 20 && sb.size() != 0; i++) step();
    nvec++;
    if (sb.size() != 0) begin
      nerr++;
      $display("FAIL drain: %0d left, required 0", sb.size());
    end
    mon_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
